uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered byte feeder sitting directly upstream of the UART transmitter.
- Accepts bytes from the system side through a write-valid interface and stores them in a circular FIFO.
- Drains bytes one at a time into the transmitter using its tx_start/tx_data/tx_done handshake.
- Producers can burst bytes without tracking the 10-bit serial frame time.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH); pointers are ADDR_W+1 bits (extra wrap bit)

Ports:
clk  input  1  system clock, same domain as transmitter
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  push request; one byte per asserted cycle
wr_data  input  8  byte to push
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a push was attempted while full
clr_overflow  input  1  clears overflow
drain_en  input  1  1 = launch bytes to transmitter; 0 = hold (in-flight byte completes)
tx_start  output  1  start request to transmitter
tx_data  output  8  byte presented to transmitter, stable while tx_start=1
tx_done  input  1  transmitter idle/complete (1 idle, falls the cycle after start accepted)
busy  output  1  (state != IDLE) or !empty

Behaviour:
- Reset (async, reset_n=0): pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00, state=IDLE. Mid-frame reset discards all stored and in-flight bytes.
- All outputs are registered or decoded from registered state only.
- **Push:** wr_en && !full writes mem[wr_ptr], wr_ptr+1. Wrap is via the natural ADDR_W+1 rollover.
- **Full/empty:** full when pointers differ only in the MSB; empty when pointers are equal.
- **Rejected push:** wr_en && full drops the byte with no pointer change and sets overflow.
  - full is evaluated from registered state, so a push while full is rejected even if a pop occurs the same cycle.
- **overflow:** clr_overflow clears it. If clr_overflow and a rejected push occur in the same cycle, set wins.
- **Simultaneous push and pop when not full:** both occur, count unchanged. A push to an empty FIFO is visible (empty=0) the next cycle.
- **FSM state IDLE:**
  - tx_start=0.
  - If drain_en && !empty && tx_done: tx_data<=mem[rd_ptr], rd_ptr+1 (pop), tx_start<=1, go to LAUNCH.
- **FSM state LAUNCH:**
  - tx_start held 1 and tx_data held stable.
  - When tx_done==0 is sampled (transmitter accepted): tx_start<=0, go to WAIT_DONE.
  - drain_en falling in LAUNCH has no effect; the launch completes.
- **FSM state WAIT_DONE:**
  - tx_start=0.
  - When tx_done==1: go to IDLE. The next byte may launch on the following cycle, giving back-to-back frames with a 2-cycle gap.
- **Latency:** push at cycle N into an empty FIFO with tx_done=1 and drain_en=1 gives empty=0 at N+1 and tx_start=1 at N+2.
- **Pop timing:** exactly one pop per frame, occurring at the IDLE->LAUNCH transition. count decrements at that edge.
- **drain_en=0:** no new launch. A byte in LAUNCH or WAIT_DONE completes normally and pushes continue.
- **tx_done=0 while IDLE:** the transmitter is owned elsewhere or still busy, so the block waits.
- **count:** count = wr_ptr - rd_ptr in ADDR_W+1-bit modulo arithmetic.

Test Plan:
- Reset and defaults: hold reset_n=0 with wr_en=1 -> empty=1, count=0, tx_start=0, overflow=0. Release, then push 8'hA5 at cycle N with a model transmitter (tx_done drops 1 cycle after tx_start) -> tx_start=1 at N+2 with tx_data=8'hA5, and exactly one frame is transmitted.
- Burst ordering: push 8'h01..8'h05 on consecutive cycles -> the transmitter receives 01,02,03,04,05 in order, count peaks at 5 and returns to 0, and busy falls only after the last tx_done rise.
- Full/overflow: with drain_en=0, push 17 bytes (DEPTH=16) -> full=1 after the 16th, the 17th is dropped, and overflow=1. Pulse clr_overflow -> overflow=0. Set drain_en=1 -> exactly 16 bytes are sent in order.
- Pointer wrap: interleave pushes and drains totalling 40 bytes (0x00..0x27) -> all 40 are received in order with no loss or duplication, and count never exceeds 16.
- Simultaneous events: at count=3, push in the same cycle as the IDLE pop -> count stays 3. At full, push during the pop cycle -> rejected and overflow=1. clr_overflow coincident with a rejected push -> overflow stays 1.
- Reset mid-operation: assert reset_n=0 while in WAIT_DONE with 4 bytes queued -> tx_start=0 and empty=1 immediately. After release, with no pushes, tx_start stays 0 for 100 cycles.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte-feeder bundle: system-side push/status signals plus the transmitter
// start/data/done handshake. The slave modport is the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clr_overflow;
  logic              drain_en;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              busy;

  modport slave (
    input  wr_en, wr_data, clr_overflow, drain_en, tx_done,
    output full, empty, count, overflow, tx_start, tx_data, busy
  );

  modport master (
    output wr_en, wr_data, clr_overflow, drain_en, tx_done,
    input  full, empty, count, overflow, tx_start, tx_data, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter; one byte is popped per frame
// and held on tx_data until the transmitter drops tx_done to accept it.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  state_e            state_q;
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic              overflow_q;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;
  logic [7:0]        mem_q [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic reject;
  logic pop;

  // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q == {~rd_ptr_q[ADDR_W], rd_ptr_q[ADDR_W-1:0]});
  assign push   = bus.wr_en && !full;
  assign reject = bus.wr_en && full;
  assign pop    = (state_q == IDLE) && bus.drain_en && !empty && bus.tx_done;

  // NOTE: storage array has no reset; stale contents are unreachable because
  // the pointers are reset, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      // A rejected push in the same cycle as a clear leaves the flag set.
      if (reject) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q[ADDR_W-1:0]];
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          // The transmitter signals acceptance by dropping tx_done.
          if (!bus.tx_done) begin
            tx_start_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = wr_ptr_q - rd_ptr_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based model checked every cycle, a simple
// transmitter responder, and directed scenarios with literal expectations.
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int FRAME  = 4;

  logic clk = 1'b0;
  logic reset_n;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int max_cnt = 0;
  int tx_left = 0;

  logic [7:0] rx_q [$];
  logic [7:0] mq   [$];
  bit         m_ovf;
  bit         m_start;
  bit         m_open;
  logic [7:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    tick();
    while (bus.busy && n < 400) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, n < 400, 1'b1);
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp [$]);
    check({name, "_rx_len"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      check({name, "_rx_byte"}, rx_q[i], exp[i]);
    end
    rx_q.delete();
  endtask

  // Transmitter: accepts a start while idle, drops tx_done the following
  // cycle and holds it low for FRAME cycles.
  initial begin
    bit accept;
    bus.tx_done = 1'b1;
    forever begin
      @(negedge clk);
      accept = reset_n && bus.tx_start && bus.tx_done;
      if (accept) rx_q.push_back(bus.tx_data);
      @(posedge clk);
      #1;
      if (accept) begin
        bus.tx_done = 1'b0;
        tx_left     = FRAME;
      end else if (!bus.tx_done) begin
        tx_left--;
        if (tx_left == 0) bus.tx_done = 1'b1;
      end
    end
  end

  // Model: queue occupancy plus an open-frame flag spanning launch to tx_done return.
  initial begin
    bit launch;
    bit was_full;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_start = 1'b0;
        m_open  = 1'b0;
        m_data  = 8'h00;
      end
      if (bus.count > max_cnt) max_cnt = bus.count;
      check("count",    bus.count,    mq.size());
      check("empty",    bus.empty,    mq.size() == 0);
      check("full",     bus.full,     mq.size() == DEPTH);
      check("overflow", bus.overflow, m_ovf);
      check("tx_start", bus.tx_start, m_start);
      check("tx_data",  bus.tx_data,  m_data);
      check("busy",     bus.busy,     m_open || mq.size() != 0);
      if (reset_n) begin
        was_full = (mq.size() == DEPTH);
        launch   = !m_open && bus.drain_en && mq.size() != 0 && bus.tx_done;
        if (bus.wr_en && was_full) m_ovf = 1'b1;
        else if (bus.clr_overflow) m_ovf = 1'b0;
        if (m_start && !bus.tx_done) m_start = 1'b0;
        else if (m_open && !m_start && bus.tx_done) m_open = 1'b0;
        if (launch) begin
          m_data  = mq.pop_front();
          m_start = 1'b1;
          m_open  = 1'b1;
        end
        if (bus.wr_en && !was_full) mq.push_back(bus.wr_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp [$];
    int next;
    int guard;
    int starts;
    bit found;

    reset_n          = 1'b0;
    bus.wr_en        = 1'b1;
    bus.wr_data      = 8'h11;
    bus.clr_overflow = 1'b0;
    bus.drain_en     = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_empty",    bus.empty,    1'b1);
    check("rst_count",    bus.count,    0);
    check("rst_tx_start", bus.tx_start, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    reset_n   = 1'b1;
    bus.wr_en = 1'b0;
    tick();
    tick();

    // Single byte latency: push in cycle N, start visible in N+2.
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    check("lat_empty_n1", bus.empty,    1'b0);
    check("lat_start_n1", bus.tx_start, 1'b0);
    tick();
    check("lat_start_n2", bus.tx_start, 1'b1);
    check("lat_data_n2",  bus.tx_data,  8'hA5);
    wait_idle("t1");
    exp = {8'hA5};
    check_rx("t1", exp);

    // Burst ordering.
    bus.drain_en = 1'b0;
    max_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    check("t2_count5", bus.count, 5);
    bus.drain_en = 1'b1;
    wait_idle("t2");
    check("t2_peak", max_cnt, 5);
    check("t2_done_at_idle", bus.tx_done, 1'b1);
    check("t2_count0", bus.count, 0);
    exp = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_rx("t2", exp);

    // Full and overflow.
    bus.drain_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check("t3_full_after16", bus.full, 1'b1);
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h10 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    check("t3_full",     bus.full,     1'b1);
    check("t3_count16",  bus.count,    16);
    check("t3_overflow", bus.overflow, 1'b1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("t3_ovf_clr", bus.overflow, 1'b0);
    bus.drain_en = 1'b1;
    wait_idle("t3");
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(8'(8'h10 + i));
    check_rx("t3", exp);

    // Pointer wrap: producer faster than drain, gated on full.
    max_cnt = 0;
    next    = 0;
    guard   = 0;
    while (next < 40 && guard < 2000) begin
      if (!bus.full) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'(next);
        next++;
      end else begin
        bus.wr_en = 1'b0;
      end
      tick();
      guard++;
    end
    bus.wr_en = 1'b0;
    check("t4_all_pushed", next, 40);
    wait_idle("t4");
    check("t4_peak", max_cnt, 16);
    check("t4_no_overflow", bus.overflow, 1'b0);
    exp.delete();
    for (int i = 0; i < 40; i++) exp.push_back(8'(i));
    check_rx("t4", exp);

    // Push coincident with the pop at count 3.
    bus.drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h31 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    tick();
    check("t5_count3", bus.count, 3);
    bus.drain_en = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_data  = 8'h34;
    tick();
    bus.wr_en = 1'b0;
    check("t5_push_pop_count", bus.count, 3);
    check("t5_start", bus.tx_start, 1'b1);
    wait_idle("t5a");
    exp = {8'h31, 8'h32, 8'h33, 8'h34};
    check_rx("t5a", exp);

    // Push while full during the pop cycle, then clear coincident with reject.
    bus.drain_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h40 + i);
      tick();
    end
    check("t5_full", bus.full, 1'b1);
    bus.drain_en = 1'b1;
    bus.wr_data  = 8'h99;
    tick();
    check("t5_pop_reject_count", bus.count, 15);
    check("t5_pop_reject_ovf", bus.overflow, 1'b1);
    bus.wr_data = 8'h50;
    tick();
    check("t5_refill", bus.count, 16);
    bus.wr_data      = 8'h98;
    bus.clr_overflow = 1'b1;
    tick();
    bus.wr_en        = 1'b0;
    bus.clr_overflow = 1'b0;
    check("t5_set_wins", bus.overflow, 1'b1);
    check("t5_count_held", bus.count, 16);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("t5_ovf_clr", bus.overflow, 1'b0);
    wait_idle("t5b");
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(8'(8'h40 + i));
    exp.push_back(8'h50);
    check_rx("t5b", exp);

    // Reset while a frame is in flight with 4 bytes queued.
    bus.drain_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h60 + i);
      tick();
    end
    bus.wr_en    = 1'b0;
    bus.drain_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      found = (bus.count == 4) && !bus.tx_start && !bus.tx_done;
    end
    check("t6_reached_wait", found, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_start", bus.tx_start, 1'b0);
    check("t6_rst_empty", bus.empty,    1'b1);
    check("t6_rst_count", bus.count,    0);
    tick();
    tick();
    reset_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.tx_start) starts++;
    end
    check("t6_no_start", starts, 0);
    check("t6_idle", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
